gobou_ctrl_core: RTL and testbench

Sequencer that drives the control and address side of the fully-connected datapath: MAC accumulate, bias register, bias add, ReLU, plus the input-image and weight memory read addresses. It sits directly upstream of the CORE parallel MAC/bias/ReLU lanes and walks one output-neuron group at a time. It strobes each stage's enables with fixed pipeline alignment and emits a write strobe for the downstream output serializer.

---
 rtl/gobou_ctrl_core_pkg.sv | 20 ++
 rtl/gobou_ctrl_core_if.sv | 40 ++++
 rtl/gobou_ctrl_delay.sv | 25 ++
 rtl/gobou_ctrl_core.sv | 131 +++++++++++++
 tb/tb_gobou_ctrl_core.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gobou_ctrl_core_pkg.sv
// rtl/gobou_ctrl_core_pkg.sv - shared constants, state type and lane-count helper for the FC sequencer
package gobou_ctrl_core_pkg;

   localparam int CORE    = 16;
   localparam int IWIDTH  = 12;
   localparam int AWIDTH  = 16;
   localparam int RD_LAT  = 1;
   localparam int MAC_LAT = 2;
   localparam int NWIDTH  = $clog2(CORE) + 1;
   localparam int FLUSH   = RD_LAT + MAC_LAT + 3;
   localparam int FWIDTH  = $clog2(FLUSH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BIAS, S_ACCUM, S_FLUSH} state_t;

   // Lanes occupied by a group given the neurons still to be produced.
   function automatic logic [NWIDTH-1:0] grp_lanes(input logic [IWIDTH-1:0] rem);
      return (rem > IWIDTH'(CORE)) ? NWIDTH'(CORE) : rem[NWIDTH-1:0];
   endfunction

endpackage

// File: rtl/gobou_ctrl_core_if.sv
// rtl/gobou_ctrl_core_if.sv - request, memory-address and lane-strobe bundle of the FC sequencer
interface gobou_ctrl_core_if;
   import gobou_ctrl_core_pkg::*;

   logic              req;
   logic [IWIDTH-1:0] in_size;
   logic [IWIDTH-1:0] out_size;
   logic [AWIDTH-1:0] img_base;
   logic [AWIDTH-1:0] net_base;
   logic              bias_en;
   logic              relu_en;
   logic              ack;
   logic              mem_en;
   logic [AWIDTH-1:0] img_addr;
   logic [AWIDTH-1:0] net_addr;
   logic              accum_rst;
   logic              accum_we;
   logic              breg_we;
   logic              mac_oe;
   logic              bias_oe;
   logic              relu_oe;
   logic              _bias_en;
   logic              _relu_en;
   logic              out_we;
   logic [IWIDTH-1:0] out_grp;
   logic [NWIDTH-1:0] out_num;

   modport master (
      output req, in_size, out_size, img_base, net_base, bias_en, relu_en,
      input  ack, mem_en, img_addr, net_addr, accum_rst, accum_we, breg_we,
             mac_oe, bias_oe, relu_oe, _bias_en, _relu_en, out_we, out_grp, out_num
   );

   modport slave (
      input  req, in_size, out_size, img_base, net_base, bias_en, relu_en,
      output ack, mem_en, img_addr, net_addr, accum_rst, accum_we, breg_we,
             mac_oe, bias_oe, relu_oe, _bias_en, _relu_en, out_we, out_grp, out_num
   );

endinterface

// File: rtl/gobou_ctrl_delay.sv
// rtl/gobou_ctrl_delay.sv - resettable shift register aligning a strobe lane to the datapath
module gobou_ctrl_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] pipe [DEPTH];

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DEPTH-1];

endmodule

// File: rtl/gobou_ctrl_core.sv
// rtl/gobou_ctrl_core.sv - FC sequencer: walks neuron groups, issues reads and aligned lane strobes
module gobou_ctrl_core
   import gobou_ctrl_core_pkg::*;
(
   input logic              clk,
   input logic              xrst,
   gobou_ctrl_core_if.slave bus
);

   state_t            state;
   logic [IWIDTH-1:0] n;
   logic [IWIDTH-1:0] k;
   logic [IWIDTH-1:0] rem;
   logic [AWIDTH-1:0] img_start;
   logic [AWIDTH-1:0] grp_base;
   logic [AWIDTH-1:0] next_base;
   logic [FWIDTH-1:0] cnt;
   logic              bias_ph;
   logic              acc_ph;
   logic              last_ph;
   logic [1:0]        ph_q;

   // Each group's weights are N+1 words: the bias followed by N weights.
   assign next_base = grp_base + AWIDTH'(n) + AWIDTH'(1);

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state        <= S_IDLE;
         bus.ack      <= 1'b1;
         bus.mem_en   <= 1'b0;
         bus.img_addr <= '0;
         bus.net_addr <= '0;
         bus.out_grp  <= '0;
         bus.out_num  <= '0;
         bus._bias_en <= 1'b0;
         bus._relu_en <= 1'b0;
         n            <= '0;
         k            <= '0;
         rem          <= '0;
         img_start    <= '0;
         grp_base     <= '0;
         cnt          <= '0;
         bias_ph      <= 1'b0;
         acc_ph       <= 1'b0;
         last_ph      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.req) begin
               n            <= bus.in_size;
               rem          <= bus.out_size;
               img_start    <= bus.img_base;
               grp_base     <= bus.net_base;
               bus._bias_en <= bus.bias_en;
               bus._relu_en <= bus.relu_en;
               if (bus.in_size != '0 && bus.out_size != '0) begin
                  state        <= S_BIAS;
                  bus.ack      <= 1'b0;
                  bus.mem_en   <= 1'b1;
                  bus.net_addr <= bus.net_base;
                  bus.out_grp  <= '0;
                  bus.out_num  <= grp_lanes(bus.out_size);
                  bias_ph      <= 1'b1;
               end
            end
            S_BIAS: begin
               state        <= S_ACCUM;
               k            <= IWIDTH'(1);
               bias_ph      <= 1'b0;
               acc_ph       <= 1'b1;
               last_ph      <= (n == IWIDTH'(1));
               bus.img_addr <= img_start;
               bus.net_addr <= grp_base + AWIDTH'(1);
            end
            S_ACCUM: if (k == n) begin
               state      <= S_FLUSH;
               bus.mem_en <= 1'b0;
               acc_ph     <= 1'b0;
               last_ph    <= 1'b0;
               cnt        <= '0;
            end else begin
               k            <= k + IWIDTH'(1);
               last_ph      <= (k + IWIDTH'(1) == n);
               bus.img_addr <= bus.img_addr + AWIDTH'(1);
               bus.net_addr <= bus.net_addr + AWIDTH'(1);
            end
            S_FLUSH: if (cnt != FWIDTH'(FLUSH - 1)) begin
               cnt <= cnt + FWIDTH'(1);
            end else if (rem <= IWIDTH'(CORE)) begin
               state   <= S_IDLE;
               bus.ack <= 1'b1;
            end else begin
               state        <= S_BIAS;
               rem          <= rem - IWIDTH'(CORE);
               bus.out_grp  <= bus.out_grp + IWIDTH'(1);
               bus.out_num  <= grp_lanes(rem - IWIDTH'(CORE));
               grp_base     <= next_base;
               bus.net_addr <= next_base;
               bus.mem_en   <= 1'b1;
               bias_ph      <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Address-phase flags become lane strobes once the read data has arrived.
   gobou_ctrl_delay #(.WIDTH(2), .DEPTH(RD_LAT)) u_rd (
      .clk(clk), .xrst(xrst), .d({bias_ph, acc_ph}), .q(ph_q)
   );

   assign bus.breg_we   = ph_q[1];
   assign bus.accum_rst = ph_q[1];
   assign bus.accum_we  = ph_q[0];

   gobou_ctrl_delay #(.WIDTH(1), .DEPTH(RD_LAT + MAC_LAT)) u_mac (
      .clk(clk), .xrst(xrst), .d(last_ph), .q(bus.mac_oe)
   );

   gobou_ctrl_delay #(.WIDTH(1), .DEPTH(1)) u_bias (
      .clk(clk), .xrst(xrst), .d(bus.mac_oe), .q(bus.bias_oe)
   );

   gobou_ctrl_delay #(.WIDTH(1), .DEPTH(1)) u_relu (
      .clk(clk), .xrst(xrst), .d(bus.bias_oe), .q(bus.relu_oe)
   );

   gobou_ctrl_delay #(.WIDTH(1), .DEPTH(1)) u_out (
      .clk(clk), .xrst(xrst), .d(bus.relu_oe), .q(bus.out_we)
   );

endmodule

// File: tb/tb_gobou_ctrl_core.sv
// tb/tb_gobou_ctrl_core.sv - scoreboard bench for gobou_ctrl_core with a behavioural lane model
module tb_gobou_ctrl_core;

   localparam int RD  = 1;
   localparam int MAC = 2;
   localparam int F   = RD + MAC + 3;

   localparam logic [6:0] ST_BREG = 7'b1100000;
   localparam logic [6:0] ST_ACC  = 7'b0010000;
   localparam logic [6:0] ST_MAC  = 7'b0001000;
   localparam logic [6:0] ST_BOE  = 7'b0000100;
   localparam logic [6:0] ST_ROE  = 7'b0000010;
   localparam logic [6:0] ST_OWE  = 7'b0000001;

   typedef struct { int cyc; logic [15:0] img; logic [15:0] net; bit bias; } rd_t;
   typedef struct { int cyc; logic [6:0] strb; int grp; int num; bit be; bit re; int res; } st_t;
   typedef struct { int cyc; bit val; } ak_t;

   logic clk = 1'b0;
   logic xrst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   rd_t rd_q[$];
   st_t st_q[$];
   ak_t ak_q[$];

   gobou_ctrl_core_if bus ();

   gobou_ctrl_core dut (.clk(clk), .xrst(xrst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int img_w(input logic [15:0] a);
      return int'(32'(a) % 32'd19) - 9;
   endfunction

   function automatic int net_w(input logic [15:0] a);
      return int'((32'(a) * 32'd5 + 32'd3) % 32'd23) - 11;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm, input longint act);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected 0x%0h at cycle %0d, nothing required", nm, act, cyc);
   endtask

   // Single lane fed by a memory whose contents are a fixed function of address.
   int di, dn, acc, breg, macv, bv, rv;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         di <= img_w(bus.img_addr);
         dn <= net_w(bus.net_addr);
      end
      if (bus.accum_rst) acc <= 0;
      else if (bus.accum_we) acc <= acc + di * dn;
      if (bus.breg_we) breg <= dn;
      if (bus.mac_oe) macv <= acc;
      if (bus.bias_oe) bv <= bus._bias_en ? macv + breg : macv;
      if (bus.relu_oe) rv <= (bus._relu_en && bv < 0) ? 0 : bv;
   end

   logic [6:0] s;
   logic       ack_prev = 1'b1;
   rd_t        r;
   st_t        e;
   ak_t        a;
   bit         owe;

   always @(negedge clk) begin
      s = {bus.breg_we, bus.accum_rst, bus.accum_we, bus.mac_oe, bus.bias_oe, bus.relu_oe, bus.out_we};
      if (bus.mem_en === 1'b1) begin
         if (rd_q.size() == 0) flag("read_extra", {bus.img_addr, bus.net_addr});
         else begin
            r = rd_q.pop_front();
            chk("read", {32'(cyc), (r.bias ? r.img : bus.img_addr), bus.net_addr},
                        {32'(r.cyc), r.img, r.net});
         end
      end
      if (s != 7'd0) begin
         if (st_q.size() == 0) flag("strobe_extra", 64'(s));
         else begin
            e = st_q.pop_front();
            owe = e.strb[0];
            chk("strobe", {24'(cyc), s, (owe ? 12'(bus.out_grp) : 12'(e.grp)),
                           (owe ? 5'(bus.out_num) : 5'(e.num)),
                           (owe ? bus._bias_en : e.be), (owe ? bus._relu_en : e.re)},
                          {24'(e.cyc), e.strb, 12'(e.grp), 5'(e.num), e.be, e.re});
            if (owe) chk("lane_result", 64'(rv), 64'(e.res));
         end
      end
      if (bus.ack !== ack_prev) begin
         if (ak_q.size() == 0) flag("ack_extra", 64'(bus.ack));
         else begin
            a = ak_q.pop_front();
            chk("ack", {32'(cyc), 31'd0, bus.ack}, {32'(a.cyc), 31'd0, a.val});
         end
      end
      ack_prev = bus.ack;
   end

   task automatic start(input int n, input int m, input logic [15:0] ib, input logic [15:0] nb,
                        input bit be, input bit re, output int t0);
      int g_cnt, p, sg, ml, sum, v;
      logic [15:0] base;
      @(negedge clk);
      bus.in_size  = 12'(n);
      bus.out_size = 12'(m);
      bus.img_base = ib;
      bus.net_base = nb;
      bus.bias_en  = be;
      bus.relu_en  = re;
      bus.req      = 1'b1;
      t0 = cyc;
      if (n > 0 && m > 0) begin
         g_cnt = (m + 15) / 16;
         p = 1 + n + F;
         ak_q.push_back(ak_t'{t0 + 1, 1'b0});
         for (int g = 0; g < g_cnt; g++) begin
            sg   = t0 + 1 + g * p;
            base = nb + 16'(g * (n + 1));
            rd_q.push_back(rd_t'{sg, 16'h0, base, 1'b1});
            st_q.push_back(st_t'{sg + RD, ST_BREG, 0, 0, 1'b0, 1'b0, 0});
            sum = 0;
            for (int k = 1; k <= n; k++) begin
               rd_q.push_back(rd_t'{sg + k, ib + 16'(k - 1), base + 16'(k), 1'b0});
               st_q.push_back(st_t'{sg + RD + k, ST_ACC, 0, 0, 1'b0, 1'b0, 0});
               sum += img_w(ib + 16'(k - 1)) * net_w(base + 16'(k));
            end
            v  = be ? sum + net_w(base) : sum;
            ml = sg + n + RD + MAC;
            st_q.push_back(st_t'{ml,     ST_MAC, 0, 0, 1'b0, 1'b0, 0});
            st_q.push_back(st_t'{ml + 1, ST_BOE, 0, 0, 1'b0, 1'b0, 0});
            st_q.push_back(st_t'{ml + 2, ST_ROE, 0, 0, 1'b0, 1'b0, 0});
            st_q.push_back(st_t'{ml + 3, ST_OWE, g, (g == g_cnt - 1) ? m - 16 * g : 16,
                                 be, re, (re && v < 0) ? 0 : v});
         end
         ak_q.push_back(ak_t'{t0 + 1 + g_cnt * p, 1'b1});
      end
      @(negedge clk);
      bus.req = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (ak_q.size() == 0 && bus.ack === 1'b1) break;
         @(negedge clk);
      end
      if (i == 3000) flag("idle_timeout", 64'(ak_q.size()));
      @(negedge clk);
   endtask

   task automatic run(input int n, input int m, input logic [15:0] ib, input logic [15:0] nb,
                      input bit be, input bit re, input bit busy);
      int t0;
      start(n, m, ib, nb, be, re, t0);
      if (busy) begin
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req = 1'($urandom_range(0, 1));
         end
         bus.req = 1'b0;
      end
      wait_idle();
   endtask

   task automatic abort_run();
      int t0, ac, i;
      start(5, 30, 16'h0400, 16'h0800, 1'b1, 1'b0, t0);
      ac = t0 + 1 + (1 + 5 + F) + 2;
      for (i = 0; i < 200 && cyc < ac; i++) begin
         @(posedge clk);
         #1;
      end
      xrst = 1'b0;
      while (rd_q.size() > 0 && rd_q[$].cyc >= ac) void'(rd_q.pop_back());
      while (st_q.size() > 0 && st_q[$].cyc >= ac) void'(st_q.pop_back());
      while (ak_q.size() > 0 && ak_q[$].cyc >= ac) void'(ak_q.pop_back());
      ak_q.push_back(ak_t'{cyc, 1'b1});
      #1;
      chk("abort_mem_en", 64'(bus.mem_en), 64'd0);
      chk("abort_out_grp", 64'(bus.out_grp), 64'd0);
      @(negedge clk);
      @(negedge clk);
      xrst = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      xrst         = 1'b0;
      bus.req      = 1'b1;
      bus.in_size  = 12'd4;
      bus.out_size = 12'd3;
      bus.img_base = 16'h1234;
      bus.net_base = 16'h4321;
      bus.bias_en  = 1'b1;
      bus.relu_en  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ack", 64'(bus.ack), 64'd1);
      chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_strobes", 64'({bus.breg_we, bus.accum_rst, bus.accum_we, bus.mac_oe,
                              bus.bias_oe, bus.relu_oe, bus.out_we}), 64'd0);
      chk("rst_addr", 64'({bus.img_addr, bus.net_addr}), 64'd0);
      chk("rst_out_grp", 64'(bus.out_grp), 64'd0);
      chk("rst_out_num", 64'(bus.out_num), 64'd0);
      chk("rst_cfg", 64'({bus._bias_en, bus._relu_en}), 64'd0);
      bus.req = 1'b0;
      xrst    = 1'b1;
      repeat (2) @(negedge clk);

      run(4, 3, 16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0);
      run(3, 20, 16'h0010, 16'h0020, 1'b1, 1'b0, 1'b0);
      run(0, 5, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      run(3, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("zero_size_ack", 64'(bus.ack), 64'd1);
      abort_run();
      run(2, 17, 16'h0040, 16'h0080, 1'b0, 1'b1, 1'b0);
      run(4, 5, 16'hFFFE, 16'hFFF0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++)
         run($urandom_range(1, 6), $urandom_range(1, 40), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      chk("reads_left", 64'(rd_q.size()), 64'd0);
      chk("strobes_left", 64'(st_q.size()), 64'd0);
      chk("acks_left", 64'(ak_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
